// File: rtl/plot_sink_pkg.sv
// plot_sink_pkg: screen geometry, colour constants and helpers shared by the pixel sink and all drawers.
package plot_sink_pkg;
  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int COL_W      = 3;
  localparam int ADDR_W     = 15;
  localparam int FIFO_DEPTH = 4;
  localparam int X_W        = 8;
  localparam int Y_W        = 7;
  localparam int PIX_W      = X_W + Y_W + COL_W;
  localparam logic [COL_W-1:0] COL_BLACK = 3'b000;
  localparam logic [COL_W-1:0] COL_WHITE = 3'b111;
  typedef enum logic {IDLE, WRITE} state_t;
  // y*160 + x as two shifts and an add
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ({8'b0, y} << 7) + ({8'b0, y} << 5) + {7'b0, x};
  endfunction
endpackage

// File: rtl/plot_sink_pixel_fifo.sv
// pixel_fifo: synchronous FIFO of packed {x, y, colour} pixels with active-low flush.
module pixel_fifo
  import plot_sink_pkg::*;
#(
  parameter int W     = PIX_W,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = wr_ptr == rd_ptr;
  assign full  = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  always_ff @(posedge clk)
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/plot_sink.sv
// plot_sink: clips and buffers plotted pixels, then writes them to the framebuffer under a grant handshake.
module plot_sink
  import plot_sink_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              plot,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  input  logic [COL_W-1:0]  col_in,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [COL_W-1:0]  mem_data,
  output logic              mem_wren,
  input  logic              mem_grant,
  output logic [7:0]        clip_count,
  output logic [ADDR_W-1:0] pixel_count,
  output logic              frame_done
);
  state_t             state, state_nx;
  logic               full, empty, push, pop, on_screen, last_pix, granted;
  logic [PIX_W-1:0]   head;
  logic [X_W-1:0]     hx;
  logic [Y_W-1:0]     hy;
  logic [COL_W-1:0]   hc;
  assign on_screen = (x_in < X_W'(SCREEN_W)) && (y_in < Y_W'(SCREEN_H));
  assign ready     = !full;
  assign push      = plot && ready && on_screen;
  assign {hx, hy, hc} = head;
  assign granted   = mem_wren && mem_grant;
  assign last_pix  = pixel_count == ADDR_W'(SCREEN_W * SCREEN_H - 1);
  pixel_fifo u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (push),
    .pop   (pop),
    .din   ({x_in, y_in, col_in}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  always_ff @(posedge clk)
    state <= !resetn ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (empty ? IDLE : WRITE) : (mem_grant && empty ? IDLE : WRITE);
  // a grant frees the output registers, so the next head can be loaded on the same edge
  always_comb begin
    mem_wren = state == WRITE;
    pop      = !empty && (state == IDLE || mem_grant);
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_addr    <= '0;
      mem_data    <= '0;
      clip_count  <= '0;
      pixel_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      if (pop) begin
        mem_addr <= pix_addr(hx, hy);
        mem_data <= hc;
      end
      if (plot && !on_screen && clip_count != 8'hFF) clip_count <= clip_count + 8'd1;
      if (granted) pixel_count <= last_pix ? '0 : pixel_count + ADDR_W'(1);
      frame_done <= granted && last_pix;
    end
  end
endmodule

// File: tb/tb_plot_sink.sv
// tb_plot_sink: directed scoreboard bench for plot_sink.
module tb_plot_sink;
  logic        clk = 1'b0, resetn = 1'b0, plot = 1'b0, mem_grant = 1'b0;
  logic [7:0]  x_in = '0;
  logic [6:0]  y_in = '0;
  logic [2:0]  col_in = '0;
  logic        ready, mem_wren, frame_done;
  logic [14:0] mem_addr, pixel_count;
  logic [2:0]  mem_data;
  logic [7:0]  clip_count;
  int          checks = 0, passed = 0, writes = 0, fd_count = 0;
  logic [14:0] last_addr = '0, h_addr = '0;
  logic [2:0]  h_data = '0;
  logic        stall_held = 1'b0;
  logic [17:0] sb [$];
  logic [17:0] e;

  plot_sink dut (
    .clk(clk), .resetn(resetn), .plot(plot), .x_in(x_in), .y_in(y_in), .col_in(col_in),
    .ready(ready), .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_grant(mem_grant), .clip_count(clip_count), .pixel_count(pixel_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input int c, input bit accept);
    plot   = 1'b1;
    x_in   = 8'(x);
    y_in   = 7'(y);
    col_in = 3'(c);
    if (accept) sb.push_back({15'(y * 160 + x), 3'(c)});
    tick;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick;
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (frame_done) fd_count++;
      if (stall_held && mem_wren) begin
        check("stall_addr", mem_addr, h_addr);
        check("stall_data", mem_data, h_data);
      end
      stall_held = mem_wren && !mem_grant;
      h_addr = mem_addr;
      h_data = mem_data;
      if (mem_wren && mem_grant) begin
        writes++;
        last_addr = mem_addr;
        check("sb_underflow", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", mem_addr, e[17:3]);
          check("wr_data", mem_data, e[2:0]);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tick;
    tick;
    resetn = 1'b1;
    check("rst_wren", mem_wren, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 0);
    check("rst_clip", clip_count, 0);
    check("rst_pix", pixel_count, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ready", ready, 1);
    // single pixel, grant held high
    mem_grant = 1'b1;
    drive(5, 3, 6, 1);
    plot = 1'b0;
    check("lat_e0_wren", mem_wren, 0);
    tick;
    check("lat_e1_wren", mem_wren, 1);
    check("single_addr", mem_addr, 485);
    check("single_data", mem_data, 6);
    tick;
    check("single_wren_off", mem_wren, 0);
    check("single_clip", clip_count, 0);
    check("single_pix", pixel_count, 1);
    // clipping and saturation
    drive(160, 0, 1, 0);
    drive(0, 120, 1, 0);
    plot = 1'b0;
    tick;
    tick;
    check("clip_two", clip_count, 2);
    check("clip_no_write", writes, 1);
    for (int i = 0; i < 300; i++) drive(200, i % 128, 0, 0);
    plot = 1'b0;
    tick;
    check("clip_sat", clip_count, 255);
    check("clip_sat_no_write", writes, 1);
    // backpressure: five fit, the rest are lost
    mem_grant = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(i, 10, i, i < 5);
      if (i == 3) check("bp_ready_4th", ready, 1);
      if (i == 4) check("bp_ready_5th", ready, 0);
    end
    plot = 1'b0;
    tick;
    tick;
    check("bp_ready_hold", ready, 0);
    check("bp_wren", mem_wren, 1);
    check("bp_head_addr", mem_addr, 1600);
    check("bp_pending", sb.size(), 5);
    mem_grant = 1'b1;
    repeat (5) tick;
    check("bp_drained", sb.size(), 0);
    check("bp_wren_off", mem_wren, 0);
    check("bp_ready_back", ready, 1);
    check("bp_writes", writes, 6);
    check("bp_pix", pixel_count, 6);
    // grant toggling every cycle
    for (int i = 0; i < 12; i++) begin
      mem_grant = (i % 2) == 1;
      if (i < 4) drive(20 + i, 50, 7 - i, 1);
      else begin
        plot = 1'b0;
        tick;
      end
    end
    plot = 1'b0;
    mem_grant = 1'b1;
    drain(20);
    check("stall_drained", sb.size(), 0);
    check("stall_writes", writes, 10);
    // reset with pixels pending
    mem_grant = 1'b0;
    for (int i = 0; i < 3; i++) drive(1 + i, 1, 1, 0);
    plot = 1'b0;
    check("mid_pending_wren", mem_wren, 1);
    resetn = 1'b0;
    tick;
    check("mid_rst_wren", mem_wren, 0);
    check("mid_rst_clip", clip_count, 0);
    check("mid_rst_pix", pixel_count, 0);
    check("mid_rst_ready", ready, 1);
    resetn = 1'b1;
    mem_grant = 1'b1;
    repeat (5) tick;
    check("mid_no_resume", writes, 10);
    check("mid_wren_idle", mem_wren, 0);
    // full frame raster
    writes = 0;
    fd_count = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) drive(x, y, (x + y) % 8, 1);
    plot = 1'b0;
    drain(10);
    tick;
    tick;
    check("frame_drained", sb.size(), 0);
    check("frame_writes", writes, 19200);
    check("frame_last_addr", last_addr, 19199);
    check("frame_done_once", fd_count, 1);
    check("frame_pix_wrap", pixel_count, 0);
    check("frame_done_low", frame_done, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot strobe) that all screen drawers drive, e.g. the homescreen painter, key and note drawers.
- Accepts plot requests, drops off-screen coordinates, and buffers accepted pixels in a small FIFO.
- Converts each pixel to a linear framebuffer address and issues writes to the framebuffer memory port under a grant handshake.
- Sits between the drawer mux and the framebuffer RAM.

Parameters:
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- COL_W, 3, colour width in bits
- FIFO_DEPTH, 4, buffered pixels (power of two)
- ADDR_W, 15, framebuffer address width

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low; clock clk
- plot  in  1  pixel write request
- x_in  in  8  column
- y_in  in  7  row
- col_in  in  COL_W  colour
- ready  out  1  sink can accept a pixel this cycle
- mem_addr  out  ADDR_W  framebuffer write address
- mem_data  out  COL_W  framebuffer write data
- mem_wren  out  1  write request to framebuffer
- mem_grant  in  1  framebuffer accepts the write this cycle
- clip_count  out  8  saturating count of dropped off-screen pixels
- pixel_count  out  ADDR_W  completed writes in current frame
- frame_done  out  1  one-cycle pulse when a full frame has been written

Behaviour:
- Reset (resetn low at posedge):
  - FIFO flushed; FSM to IDLE.
  - mem_wren=0, mem_addr=0, mem_data=0.
  - clip_count=0, pixel_count=0, frame_done=0.
  - ready=1 from the first cycle after reset.
  - Reset mid-burst discards all pending pixels; no write is issued after the reset edge.
- Acceptance:
  - A pixel is accepted when plot && ready at a posedge.
  - ready = !fifo_full. It is a function of stored state only, never of mem_grant in the same cycle.
  - plot while ready=0: the pixel is lost and not counted. Drawers must hold or stall.
- Clipping at acceptance:
  - x_in >= SCREEN_W or y_in >= SCREEN_H: the pixel is not stored.
  - clip_count increments and saturates at 255.
  - Clipped pixels do not require ready; they are counted even when the FIFO is full.
- Address:
  - mem_addr = y*SCREEN_W + x, computed as (y<<7)+(y<<5)+x for default width.
  - Maximum address is 19199; ADDR_W bits, no overflow.
- FSM, states IDLE and WRITE:
  - IDLE: mem_wren=0. If the FIFO is non-empty, pop the head, register mem_addr and mem_data, and go to WRITE.
  - WRITE: mem_wren=1; mem_addr and mem_data are held stable until mem_grant=1.
  - On grant with the FIFO non-empty: pop the next pixel into the output registers the same edge and stay in WRITE. This gives back-to-back throughput of 1 pixel/cycle.
  - On grant with the FIFO empty: go to IDLE.
- Latency: a pixel sampled at edge E0 into an empty sink gets mem_wren high after edge E1, i.e. 1 cycle of FIFO latency.
- Simultaneous push and pop: allowed in the same cycle; occupancy is unchanged. When full, a push is still refused because ready=0 that cycle.
- Capacity: 1 pixel in the output registers plus FIFO_DEPTH in the FIFO.
- Counting:
  - pixel_count increments on each granted write.
  - On the grant that takes it from SCREEN_W*SCREEN_H-1 (19199), pixel_count wraps to 0 and frame_done pulses high for exactly one cycle.
- Ordering: writes are issued in strict acceptance order.

Decomposition:
- Shared package holds SCREEN_W, SCREEN_H, COL_W, ADDR_W and the colour constants (black=3'b000, white=3'b111), also used by all drawers.
- One sub-module: pixel_fifo, a synchronous FIFO with width 8+7+COL_W, push/pop, full/empty, and synchronous active-low flush on resetn.

Test Plan:
- Single pixel: x=5, y=3, col=6, mem_grant=1 -> mem_addr=485, mem_data=6, mem_wren high for exactly one cycle, rising after the second edge from the plot edge; clip_count=0.
- Clipping: plots at (160,0) and (0,120) -> no mem_wren, clip_count=2. Then 300 off-screen plots -> clip_count saturates at 255.
- Backpressure: mem_grant=0, 7 consecutive plots -> exactly 5 accepted, ready=0 after the 5th. Raise mem_grant -> 5 writes on consecutive cycles, in order, with correct addresses; ready returns to 1.
- Grant stall: mem_grant toggling 1/0 each cycle -> mem_addr and mem_data stay stable while wren=1 and grant=0; no duplicated or skipped pixels.
- Full frame: raster 160x120 with grant=1 -> 19200 writes, last address 19199, frame_done pulses once, pixel_count=0 afterwards.
- Reset mid-burst: resetn low while 3 pixels are pending -> mem_wren=0 from the next cycle, counts=0. No writes resume after reset releases until new plots arrive.
